alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width in bits (legal range 8..64, power of two).
REQ-002 SHALL provide parameter SHW, default $clog2(WIDTH), shift-amount width taken from DataB[SHW-1:0].
REQ-003 SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, request strobe qualifying ALUCon/DataA/DataB.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request this cycle.
REQ-007 SHALL have port ALUCon, input, 4, operation code.
REQ-008 SHALL have ports DataA and DataB, input, WIDTH each, unsigned operands.
REQ-009 SHALL have port out_valid, output, 1, Result/error are valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port Result, output, WIDTH, registered operation result.
REQ-012 SHALL have port error, output, 1, illegal opcode, disabled op, or divide-by-zero.

Function
REQ-013 SHALL decode ALUCon: 0000 and, 0001 or, 0010 add, 0011 mul, 0100 nor, 0101 div, 0110 sub, 0111 slt, 1000 sll, 1001 srl; 1010-1111 illegal.
REQ-014 SHALL accept a request only on a cycle where in_valid and in_ready are both 1, capturing opcode and operands into internal registers.
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL go IDLE->DONE on accept of single-cycle ops (and/or/add/nor/sub/slt/sll/srl/illegal); out_valid rises the cycle after accept.
REQ-017 SHALL go IDLE->BUSY on accept of mul/div, iterate exactly WIDTH cycles, then BUSY->DONE; out_valid rises WIDTH+1 cycles after accept.
REQ-018 SHALL go DONE->IDLE on the cycle out_valid and out_ready are both 1; Result and error SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 SHALL implement add/sub modulo 2^WIDTH, carry/borrow discarded.
REQ-020 SHALL implement mul as iterative shift-add, Result = low WIDTH bits of DataA*DataB.
REQ-021 SHALL implement div as restoring division, Result = floor(DataA/DataB).
REQ-022 SHALL on DataB=0 for div still spend WIDTH BUSY cycles, then present Result = all ones, error=1.
REQ-023 SHALL implement slt as unsigned compare, Result = 1 if DataA<DataB else 0, zero-extended.
REQ-024 SHALL shift by DataB[SHW-1:0] only (upper DataB bits ignored); sll/srl fill with zeros.
REQ-025 SHALL on illegal opcode produce Result=0, error=1 with single-cycle timing.
REQ-026 SHALL ignore in_valid while not in IDLE; operand changes during BUSY SHALL not affect the result.
REQ-027 SHALL keep Result and error at their last values in IDLE (not re-cleared between operations).

Reset
REQ-028 SHALL on reset=1 at a clock edge enter IDLE, set Result=0, error=0, out_valid=0, clear iteration counter and mul/div working registers.
REQ-029 SHALL drive in_ready=1 in the first cycle after reset is released.
REQ-030 SHALL abort any BUSY or DONE operation on reset with no result delivered; reset takes priority over accept and handshake.

Configuration
REQ-031 SHALL honour macro ALU_MULDIV_EN: defined -> mul/div per REQ-017, REQ-020..022; undefined -> no iterative datapath synthesized, opcodes 0011/0101 treated as illegal per REQ-025 and BUSY state never entered.

Verification
REQ-032 SHALL test add, WIDTH=32: A=0xFFFFFFFF, B=1 -> out_valid 1 cycle after accept, Result=0x00000000, error=0.
REQ-033 SHALL test mul (ALU_MULDIV_EN defined): A=0x00010003, B=0x00020005 -> out_valid exactly 33 cycles after accept, Result=0x000B000F, error=0.
REQ-034 SHALL test div by zero: A=100, B=0 -> after 33 cycles Result=0xFFFFFFFF, error=1; div A=100, B=7 -> Result=14, error=0.
REQ-035 SHALL test backpressure: sll A=1, B=0x00000024 -> Result=0x00000010; hold out_ready=0 for 5 cycles -> Result stable, in_ready=0; in_valid pulses ignored.
REQ-036 SHALL test reset mid-operation: start div, assert reset on BUSY cycle 10 -> next cycle IDLE, out_valid=0, Result=0; next request srl A=0x80000000, B=31 -> Result=1.
REQ-037 SHALL test illegal and disabled ops: ALUCon=1111 -> Result=0, error=1 after 1 cycle; ALU_MULDIV_EN undefined, ALUCon=0011 -> same response.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes. Single-cycle logic ops; optional iterative
// mul/div enabled by defining ALU_MULDIV_EN (otherwise their opcodes are illegal).
module alu_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUCon,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             error
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] sc_result;
  logic             sc_error;
  logic             is_iter;

  // Single-cycle datapath, evaluated straight from the request inputs at accept.
  always_comb begin
    sc_result = '0;
    sc_error  = 1'b0;
    is_iter   = 1'b0;
    case (ALUCon)
      4'b0000: sc_result = DataA & DataB;
      4'b0001: sc_result = DataA | DataB;
      4'b0010: sc_result = DataA + DataB;
      4'b0100: sc_result = ~(DataA | DataB);
      4'b0110: sc_result = DataA - DataB;
      4'b0111: sc_result = {{(WIDTH-1){1'b0}}, (DataA < DataB)};
      4'b1000: sc_result = DataA << DataB[SHW-1:0];
      4'b1001: sc_result = DataA >> DataB[SHW-1:0];
`ifdef ALU_MULDIV_EN
      4'b0011, 4'b0101: is_iter = 1'b1;
`endif
      default: sc_error = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [SHW:0] LastCnt = (SHW+1)'(WIDTH);

  // acc: product accumulator (mul) or partial remainder (div, one spare bit).
  // wa: shifted multiplicand (mul) or dividend/quotient (div). wb: multiplier or divisor.
  logic             div_q, div_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] wa_q, wa_d;
  logic [WIDTH-1:0] wb_q, wb_d;
  logic [WIDTH:0]   rem_sh, trial;

  assign rem_sh = {acc_q[WIDTH-1:0], wa_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, wb_q};
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    error_d  = error_q;
`ifdef ALU_MULDIV_EN
    div_d = div_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    wa_d  = wa_q;
    wb_d  = wb_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (is_iter) begin
            state_d = StBusy;
`ifdef ALU_MULDIV_EN
            div_d = (ALUCon == 4'b0101);
            cnt_d = '0;
            acc_d = '0;
            wa_d  = DataA;
            wb_d  = DataB;
`endif
          end else begin
            state_d  = StDone;
            result_d = sc_result;
            error_d  = sc_error;
          end
        end
      end
      StBusy: begin
`ifdef ALU_MULDIV_EN
        if (cnt_q != LastCnt) begin
          cnt_d = cnt_q + 1'b1;
          if (div_q) begin
            if (!trial[WIDTH]) begin
              acc_d = trial;
              wa_d  = {wa_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = rem_sh;
              wa_d  = {wa_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {1'b0, acc_q[WIDTH-1:0] + (wb_q[0] ? wa_q : '0)};
            wa_d  = wa_q << 1;
            wb_d  = wb_q >> 1;
          end
        end else begin
          // Extra cycle after the last iteration publishes the result.
          state_d = StDone;
          if (div_q) begin
            result_d = (wb_q == '0) ? '1 : wa_q;
            error_d  = (wb_q == '0);
          end else begin
            result_d = acc_q[WIDTH-1:0];
            error_d  = 1'b0;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

`ifdef ALU_MULDIV_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      wa_q  <= '0;
      wb_q  <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      wa_q  <= wa_d;
      wb_q  <= wb_d;
    end
  end
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Result    = result_q;
  assign error     = error_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=32); expectations follow ALU_MULDIV_EN.
module tb_alu_multicycle;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUCon;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUCon   (ALUCon),
    .DataA    (DataA),
    .DataB    (DataB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result   (Result),
    .error    (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble operands after accept, wait for out_valid and check it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ee,
                        input int lat, input bit release_now);
    int cyc;
    @(negedge clock);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    ALUCon    = op;
    DataA     = a;
    DataB     = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    DataA    = $urandom;
    DataB    = $urandom;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!out_valid && cyc < 100);
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " Result"}, 64'(Result), 64'(er));
    check({tag, " error"}, 64'(error), 64'(ee));
    if (release_now) begin
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check({tag, " back to idle"}, 64'({out_valid, in_ready}), 64'b01);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ALUCon    = '0;
    DataA     = '0;
    DataB     = '0;
    repeat (2) @(negedge clock);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset Result", 64'(Result), 64'd0);
    check("reset error", 64'(error), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    run_op("add wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 1'b1);
    run_op("and", 4'b0000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b0, 1, 1'b1);
    run_op("or", 4'b0001, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0, 1'b0, 1, 1'b1);
    run_op("nor", 4'b0100, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF, 1'b0, 1, 1'b1);
    run_op("sub borrow", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 1'b1);
    run_op("slt true", 4'b0111, 32'd3, 32'h8000_0000, 32'd1, 1'b0, 1, 1'b1);
    run_op("slt unsigned", 4'b0111, 32'h8000_0000, 32'd3, 32'd0, 1'b0, 1, 1'b1);
    run_op("srl upper ignored", 4'b1001, 32'h8000_0000, 32'hFFFF_FFE1, 32'h4000_0000, 1'b0,
           1, 1'b1);

    // Backpressure: result held, in_ready low, in_valid pulses ignored.
    run_op("sll", 4'b1000, 32'h1, 32'h0000_0024, 32'h10, 1'b0, 1, 1'b0);
    ALUCon = 4'b0010;
    DataA  = 32'h5;
    DataB  = 32'h5;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      @(negedge clock);
      check("bp Result stable", 64'(Result), 64'h10);
      check("bp hold", 64'({out_valid, in_ready, error}), 64'b100);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("bp release", 64'({out_valid, in_ready}), 64'b01);
    @(negedge clock);
    check("idle keeps Result", 64'(Result), 64'h10);

    run_op("illegal 1111", 4'b1111, 32'h1234_5678, 32'h9, 32'h0, 1'b1, 1, 1'b1);

`ifdef ALU_MULDIV_EN
    run_op("mul", 4'b0011, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 33, 1'b1);
    run_op("div by zero", 4'b0101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b1, 33, 1'b1);
    run_op("div", 4'b0101, 32'd100, 32'd7, 32'd14, 1'b0, 33, 1'b1);

    // Reset on the tenth BUSY cycle of a divide.
    @(negedge clock);
    ALUCon   = 4'b0101;
    DataA    = 32'd100;
    DataB    = 32'd7;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clock);
    check("busy before reset", 64'({out_valid, in_ready}), 64'b00);
`else
    run_op("mul disabled", 4'b0011, 32'h0001_0003, 32'h0002_0005, 32'h0, 1'b1, 1, 1'b1);
    run_op("div disabled", 4'b0101, 32'd100, 32'd7, 32'h0, 1'b1, 1, 1'b1);
    run_op("add pre-reset", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1'b0);
    out_ready = 1'b1;
`endif
    reset = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b0;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort Result", 64'(Result), 64'd0);
    check("abort error", 64'(error), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);

    run_op("srl after reset", 4'b1001, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
